// File: rtl/tick_gen_if.sv
// Control/status bundle for the tick generator.
// Master drives run controls; slave returns tick and debug status.
interface tick_gen_if #(
    parameter int NB_TICKCNT = 8
);
    logic                  i_enable;
    logic                  i_hold;
    logic [1:0]            i_sel;
    logic                  o_tick;
    logic                  o_valid;
    logic [1:0]            o_state;
    logic [NB_TICKCNT-1:0] o_tick_cnt;

    modport master (
        output i_enable, i_hold, i_sel,
        input  o_tick, o_valid, o_state, o_tick_cnt
    );

    modport slave (
        input  i_enable, i_hold, i_sel,
        output o_tick, o_valid, o_state, o_tick_cnt
    );
endinterface

// File: rtl/tick_gen.sv
// Programmable tick generator: one-cycle pulse at a selectable rate,
// with run/pause/stop control and a wrapping tick counter for debug.
module tick_gen #(
    parameter int              NB_COUNTER = 32,
    parameter int              NB_TICKCNT = 8,
    parameter longint unsigned LIMIT_R0   = 64'd8388607,
    parameter longint unsigned LIMIT_R1   = 64'd16777215,
    parameter longint unsigned LIMIT_R2   = 64'd33554431,
    parameter longint unsigned LIMIT_R3   = 64'd67108863
) (
    input  logic        clock,
    input  logic        i_reset,
    tick_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam longint unsigned MAX_CNT = (NB_COUNTER >= 64) ? ~64'd0
                                        : ((64'd1 << NB_COUNTER) - 64'd1);

    generate
        if (LIMIT_R0 > MAX_CNT || LIMIT_R1 > MAX_CNT ||
            LIMIT_R2 > MAX_CNT || LIMIT_R3 > MAX_CNT) begin : g_limit_chk
            $error("tick_gen: a LIMIT_Rx does not fit in NB_COUNTER bits");
        end
    endgenerate

    localparam logic [NB_COUNTER-1:0] LIM0 = NB_COUNTER'(LIMIT_R0);
    localparam logic [NB_COUNTER-1:0] LIM1 = NB_COUNTER'(LIMIT_R1);
    localparam logic [NB_COUNTER-1:0] LIM2 = NB_COUNTER'(LIMIT_R2);
    localparam logic [NB_COUNTER-1:0] LIM3 = NB_COUNTER'(LIMIT_R3);

    state_t                r_state;
    logic [NB_COUNTER-1:0] r_counter;
    logic [1:0]            r_sel_q;
    logic                  r_tick;
    logic                  r_valid;
    logic [NB_TICKCNT-1:0] r_tick_cnt;

    state_t                w_state_nxt;
    logic [NB_COUNTER-1:0] w_counter_nxt;
    logic                  w_tick_nxt;
    logic [NB_TICKCNT-1:0] w_tick_cnt_nxt;
    logic [NB_COUNTER-1:0] w_limit;

    // Terminal count for the currently requested rate.
    always_comb begin
        w_limit = LIM0;
        case (bus.i_sel)
            2'd0:    w_limit = LIM0;
            2'd1:    w_limit = LIM1;
            2'd2:    w_limit = LIM2;
            default: w_limit = LIM3;
        endcase
    end

    // Next state, counter and tick; disable beats hold beats counting,
    // and a rate change restarts the count without ticking.
    always_comb begin
        w_state_nxt    = r_state;
        w_counter_nxt  = r_counter;
        w_tick_nxt     = 1'b0;
        w_tick_cnt_nxt = r_tick_cnt;
        case (r_state)
            ST_STOP: begin
                w_counter_nxt = '0;
                if (bus.i_enable)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.i_enable) begin
                    w_state_nxt   = ST_STOP;
                    w_counter_nxt = '0;
                end else if (bus.i_hold) begin
                    w_state_nxt = ST_PAUSE;
                end else if (bus.i_sel != r_sel_q) begin
                    w_counter_nxt = '0;
                end else if (r_counter == w_limit) begin
                    w_counter_nxt  = '0;
                    w_tick_nxt     = 1'b1;
                    w_tick_cnt_nxt = r_tick_cnt + NB_TICKCNT'(1);
                end else begin
                    w_counter_nxt = r_counter + NB_COUNTER'(1);
                end
            end
            ST_PAUSE: begin
                if (!bus.i_enable) begin
                    w_state_nxt   = ST_STOP;
                    w_counter_nxt = '0;
                end else if (!bus.i_hold) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt   = ST_STOP;
                w_counter_nxt = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!i_reset)
            r_state <= ST_STOP;
        else
            r_state <= w_state_nxt;
    end

    // Counter, rate history and registered outputs.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_counter  <= '0;
            r_sel_q    <= 2'd0;
            r_tick     <= 1'b0;
            r_valid    <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_counter  <= w_counter_nxt;
            r_sel_q    <= bus.i_sel;
            r_tick     <= w_tick_nxt;
            r_valid    <= (w_state_nxt != ST_STOP);
            r_tick_cnt <= w_tick_cnt_nxt;
        end
    end

    assign bus.o_tick     = r_tick;
    assign bus.o_valid    = r_valid;
    assign bus.o_state    = r_state;
    assign bus.o_tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with small limits (3, 7, 15, 31):
// a vector table for reset/first ticks, then multi-cycle sequences.
module tb_tick_gen;

    logic clock;
    logic i_reset;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_cnt;

    tick_gen_if #(.NB_TICKCNT(8)) bus ();

    tick_gen #(
        .NB_COUNTER(32),
        .NB_TICKCNT(8),
        .LIMIT_R0  (64'd3),
        .LIMIT_R1  (64'd7),
        .LIMIT_R2  (64'd15),
        .LIMIT_R3  (64'd31)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       hold;
        logic [1:0] sel;
        int         n;
        logic       tick;
        logic       valid;
        logic [1:0] state;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic tick,
                           input logic valid, input logic [1:0] state,
                           input logic [7:0] cnt);
        chk({tag, ".tick"}, 32'(bus.o_tick), 32'(tick));
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(valid));
        chk({tag, ".state"}, 32'(bus.o_state), 32'(state));
        chk({tag, ".cnt"}, 32'(bus.o_tick_cnt), 32'(cnt));
    endtask

    // Expect `count` ticks, each preceded by period-1 quiet cycles.
    task automatic expect_ticks(input int period, input int count,
                                input string tag);
        for (int k = 0; k < count; k++) begin
            for (int c = 1; c <= period; c++) begin
                cyc();
                if (c < period) begin
                    chk({tag, ".quiet"}, 32'(bus.o_tick), 32'd0);
                end else begin
                    exp_cnt++;
                    chk({tag, ".tick"}, 32'(bus.o_tick), 32'd1);
                    chk({tag, ".cnt"}, 32'(bus.o_tick_cnt), 32'(exp_cnt));
                    chk({tag, ".state"}, 32'(bus.o_state), 32'd1);
                end
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        exp_cnt      = 8'd0;
        i_reset      = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_hold   = 1'b0;
        bus.i_sel    = 2'd0;

        // rst en hold sel n | tick valid state cnt
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0,  3, 1'b0, 1'b0, 2'b00, 8'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 20, 1'b0, 1'b0, 2'b00, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'd0,  1, 1'b0, 1'b1, 2'b01, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'd0,  3, 1'b0, 1'b1, 2'b01, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'd0,  1, 1'b1, 1'b1, 2'b01, 8'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'd0,  3, 1'b0, 1'b1, 2'b01, 8'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'd0,  1, 1'b1, 1'b1, 2'b01, 8'd2});

        #1;
        foreach (vecs[i]) begin
            i_reset      = vecs[i].rst;
            bus.i_enable = vecs[i].en;
            bus.i_hold   = vecs[i].hold;
            bus.i_sel    = vecs[i].sel;
            for (int r = 0; r < vecs[i].n; r++) begin
                cyc();
                chk_out($sformatf("vec%0d", i), vecs[i].tick,
                        vecs[i].valid, vecs[i].state, vecs[i].cnt);
            end
        end
        exp_cnt = 8'd2;

        // Basic rate 0: eight more ticks, period 4.
        expect_ticks(4, 8, "rate0");
        chk("rate0.cnt10", 32'(bus.o_tick_cnt), 32'd10);

        // Switch to slowest rate right after a tick.
        bus.i_sel = 2'd3;
        cyc();
        chk("sel3.switch", 32'(bus.o_tick), 32'd0);
        expect_ticks(32, 2, "rate3");

        // Stop, select rate 1, restart; pause with counter at 5.
        bus.i_enable = 1'b0;
        cyc();
        chk_out("stop1", 1'b0, 1'b0, 2'b00, exp_cnt);
        bus.i_sel = 2'd1;
        cyc();
        chk_out("stop1b", 1'b0, 1'b0, 2'b00, exp_cnt);
        bus.i_enable = 1'b1;
        cyc();
        chk_out("run1", 1'b0, 1'b1, 2'b01, exp_cnt);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("run1.quiet", 32'(bus.o_tick), 32'd0);
        end
        bus.i_hold = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk_out("pause", 1'b0, 1'b1, 2'b10, exp_cnt);
        end
        bus.i_hold = 1'b0;
        cyc();
        chk_out("resume", 1'b0, 1'b1, 2'b01, exp_cnt);
        expect_ticks(3, 1, "resume");
        expect_ticks(8, 1, "rate1");

        // Rate change mid-count: counter reaches 20 at rate 3.
        bus.i_sel = 2'd3;
        cyc();
        chk("mid.sel3", 32'(bus.o_tick), 32'd0);
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk("mid.count", 32'(bus.o_tick), 32'd0);
        end
        bus.i_sel = 2'd0;
        cyc();
        chk("mid.sel0", 32'(bus.o_tick), 32'd0);
        expect_ticks(4, 3, "mid.rate0");

        // Stop mid-count; counter must restart from zero.
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("pre_stop.quiet", 32'(bus.o_tick), 32'd0);
        end
        bus.i_enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk_out("stop2", 1'b0, 1'b0, 2'b00, exp_cnt);
        end
        bus.i_enable = 1'b1;
        cyc();
        chk_out("run2", 1'b0, 1'b1, 2'b01, exp_cnt);
        expect_ticks(4, 256 - int'(exp_cnt), "wrap");
        chk("wrap.cnt0", 32'(bus.o_tick_cnt), 32'd0);

        // Reset on the cycle the next tick would fire.
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("pre_rst.quiet", 32'(bus.o_tick), 32'd0);
        end
        i_reset = 1'b0;
        cyc();
        chk_out("midrst", 1'b0, 1'b0, 2'b00, 8'd0);
        exp_cnt = 8'd0;
        i_reset = 1'b1;
        cyc();
        chk_out("postrst", 1'b0, 1'b1, 2'b01, 8'd0);
        expect_ticks(4, 1, "postrst");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Programmable tick generator driving the LED-pattern stages (flash register, shift registers).
- Issues a single-cycle o_tick pulse at a switch-selected rate; the pulse is wired directly to the flash stage's i_valid and the shift stages' step-enable inputs.
- Run/pause/stop control comes from board switches.
- Also exports a wrapping tick count and state for debug LEDs.

Parameters:
- NB_COUNTER, 32, width of the cycle counter.
- NB_TICKCNT, 8, width of the wrapping tick counter.
- LIMIT_R0, 2**23-1, terminal count for rate select 0 (fastest).
- LIMIT_R1, 2**24-1, terminal count for rate select 1.
- LIMIT_R2, 2**25-1, terminal count for rate select 2.
- LIMIT_R3, 2**26-1, terminal count for rate select 3 (slowest).

Ports:
- clock  input  1  system clock; all logic on posedge.
- i_reset  input  1  synchronous, active-low reset (0 = reset).
- i_enable  input  1  level; 1 = generator allowed to run, 0 = stop.
- i_hold  input  1  level; 1 = pause (freeze counter) while running.
- i_sel  input  2  rate select; picks LIMIT_R0..LIMIT_R3.
- o_tick  output  1  one-cycle pulse at each terminal count.
- o_valid  output  1  1 while state is RUN or PAUSE.
- o_state  output  2  00 STOP, 01 RUN, 10 PAUSE.
- o_tick_cnt  output  NB_TICKCNT  number of ticks issued, wraps modulo 2**NB_TICKCNT.

Behaviour:
- Reset (i_reset==0 at posedge), all registered outputs:
  - state = STOP, counter = 0, sel_q = 0.
  - o_tick = 0, o_valid = 0, o_state = 00, o_tick_cnt = 0.
  - Reset overrides every other input, including mid-count and mid-pause.
- State machine (registered; evaluated each posedge out of reset):
  - STOP: counter held at 0. i_enable=1 -> RUN.
  - RUN: i_enable=0 -> STOP (counter cleared). Else i_hold=1 -> PAUSE. Else count.
  - PAUSE: i_enable=0 -> STOP (counter cleared). Else i_hold=0 -> RUN. Counter frozen at its current value.
  - Precedence: reset > i_enable=0 > i_hold > counting.
- Counting in RUN:
  - limit = LIMIT_R[i_sel].
  - counter == limit -> counter <= 0, o_tick <= 1, o_tick_cnt <= o_tick_cnt+1 (wraps).
  - Otherwise counter <= counter+1, o_tick <= 0.
- Tick latency: first o_tick is asserted limit+1 cycles after the first posedge in RUN; period is then limit+1 cycles.
- o_tick is registered, never high for more than one consecutive cycle unless limit==0, in which case it is high every RUN cycle.
- o_tick is 0 in STOP and PAUSE.
- Rate change: sel_q registers i_sel every cycle. If i_sel != sel_q in RUN, counter <= 0 and no tick is issued that cycle; counting restarts against the new limit. In PAUSE/STOP, a rate change only updates sel_q.
- Counter never exceeds the active limit; counter width is NB_COUNTER, and limits must fit (elaboration check).
- o_valid and o_state are registered from the next state, so they change in the same cycle as the state.
- o_tick_cnt is held in STOP/PAUSE and cleared only by reset.

Test Plan:
All scenarios use LIMIT_R0..R3 = 3, 7, 15, 31.
1. Reset/idle: hold i_reset=0 for 3 cycles, then 1 with i_enable=0 -> o_state=00, o_tick=0, o_valid=0, o_tick_cnt=0 for 20 cycles.
2. Basic rate: i_enable=1, i_sel=0 -> o_state=01 and o_valid=1 after 1 cycle; o_tick pulses every 4 cycles, first on the 4th RUN cycle; after 10 ticks o_tick_cnt=10. Repeat with i_sel=3 -> period 32.
3. Pause: i_sel=1, i_hold=1 after 5 RUN cycles (counter=5) for 10 cycles -> o_state=10, no ticks, counter frozen at 5. Release -> o_state=01, first tick exactly 3 cycles later.
4. Rate change mid-count: i_sel=3 with counter=20, switch to i_sel=0 -> counter cleared, no tick that cycle, next tick 4 cycles later, then period 4.
5. Stop/restart and wrap: i_enable=0 mid-count -> STOP, counter=0, o_tick_cnt held. Run 256 ticks total -> o_tick_cnt wraps to 0.
6. Reset mid-operation: assert i_reset=0 during RUN on the cycle o_tick would fire -> no tick; all outputs at reset values next cycle.
